// File: rtl/inst_queue_mw_pkg.sv
// Shared types for the multi-lane instruction queue: the fetched-instruction
// payload and the branch-prediction info it carries.
package inst_queue_mw_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned EXC_N   = 6;
    localparam int unsigned CAUSE_W = 7;

    typedef struct packed {
        logic            is_branch;
        logic            pre_taken_or_not;
        logic [XLEN-1:0] pre_branch_addr;
    } branch_info_t;

    typedef struct packed {
        logic [XLEN-1:0]                pc;
        logic [XLEN-1:0]                inst;
        branch_info_t                   branch_info;
        logic [EXC_N-1:0]               is_exception;
        logic [EXC_N-1:0][CAUSE_W-1:0]  exception_cause;
    } inst_entry_t;

    localparam int unsigned ENTRY_W = $bits(inst_entry_t);

    // A predicted-taken branch ends the useful part of its fetch group.
    function automatic logic is_taken(input inst_entry_t e);
        return e.branch_info.is_branch & e.branch_info.pre_taken_or_not;
    endfunction

endpackage

// File: rtl/inst_compact.sv
// Fetch-group squash and compaction: keeps valid slots up to and including the
// first kept predicted-taken branch and lists them in ascending slot order.
module inst_compact #(
    parameter  int unsigned FETCH_WIDTH = 2,
    localparam int unsigned SEL_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int unsigned CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]             i_valid,
    input  logic [FETCH_WIDTH-1:0]             i_taken,
    output logic [FETCH_WIDTH-1:0]             o_keep_c,
    output logic [FETCH_WIDTH-1:0][SEL_W-1:0]  o_sel_c,
    output logic [CNT_W-1:0]                   o_npush_c
);

    logic [FETCH_WIDTH-1:0][CNT_W-1:0] w_pre;
    logic                              w_stop;

    // w_pre[j] is the number of kept slots older than slot j
    always_comb begin
        o_keep_c  = '0;
        o_npush_c = '0;
        w_pre     = '0;
        w_stop    = 1'b0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            w_pre[j] = o_npush_c;
            if (i_valid[j] && !w_stop) begin
                o_keep_c[j] = 1'b1;
                o_npush_c   = o_npush_c + CNT_W'(1);
                w_stop      = i_taken[j];
            end
        end
    end

    always_comb begin
        o_sel_c = '0;
        for (int p = 0; p < FETCH_WIDTH; p++) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (o_keep_c[j] && (w_pre[j] == CNT_W'(p))) begin
                    o_sel_c[p] = SEL_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/inst_queue_mw.sv
// Shared circular instruction queue between fetch and decode: packs up to
// FETCH_WIDTH slots per cycle, presents ISSUE_WIDTH head entries, prefix pop.
module inst_queue_mw
    import inst_queue_mw_pkg::*;
#(
    parameter  int unsigned FETCH_WIDTH = 2,
    parameter  int unsigned ISSUE_WIDTH = 2,
    parameter  int unsigned DEPTH       = 32,
    localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                stall,
    input  logic [FETCH_WIDTH-1:0]              fetch_valid,
    input  inst_entry_t [FETCH_WIDTH-1:0]       fetch_entry,
    output logic                                fetch_ready,
    output logic [ISSUE_WIDTH-1:0]              issue_valid,
    output inst_entry_t [ISSUE_WIDTH-1:0]       issue_entry,
    input  logic [ISSUE_WIDTH-1:0]              issue_accept,
    output logic [CNT_W-1:0]                    count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = $clog2(FETCH_WIDTH + 1);
    localparam int unsigned ICNT_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned SEL_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [ENTRY_W-1:0]                r_mem [DEPTH];
    logic [PTR_W-1:0]                  r_head;
    logic [PTR_W-1:0]                  r_tail;
    logic [CNT_W-1:0]                  r_count;

    logic [FETCH_WIDTH-1:0]            w_taken;
    logic [FETCH_WIDTH-1:0]            w_keep;
    logic [FETCH_WIDTH-1:0][SEL_W-1:0] w_sel;
    logic [FCNT_W-1:0]                 w_npush_raw;
    logic [FCNT_W-1:0]                 w_npush;
    logic [ICNT_W-1:0]                 w_npop;
    logic                              w_run;
    logic                              w_push;

    always_comb begin
        w_taken = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            w_taken[j] = is_taken(fetch_entry[j]);
        end
    end

    inst_compact #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compact (
        .i_valid   (fetch_valid),
        .i_taken   (w_taken),
        .o_keep_c  (w_keep),
        .o_sel_c   (w_sel),
        .o_npush_c (w_npush_raw)
    );

    // Conservative: only accept when a full group is guaranteed to fit
    assign fetch_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_WIDTH);
    assign w_push      = fetch_ready & ~flush;
    assign w_npush     = w_push ? w_npush_raw : '0;
    assign count       = r_count;

    always_comb begin
        issue_valid = '0;
        issue_entry = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if ((r_count > CNT_W'(i)) && !stall) begin
                issue_valid[i] = 1'b1;
                issue_entry[i] = inst_entry_t'(r_mem[r_head + PTR_W'(i)]);
            end
        end
    end

    // Only the leading run of accepted valid lanes is popped
    always_comb begin
        w_npop = '0;
        w_run  = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            w_run = w_run & issue_valid[i] & issue_accept[i];
            if (w_run) begin
                w_npop = w_npop + ICNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < FETCH_WIDTH; p++) begin
            if (w_push && (FCNT_W'(p) < w_npush_raw) && w_keep[w_sel[p]]) begin
                r_mem[r_tail + PTR_W'(p)] <= fetch_entry[w_sel[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_npop);
            r_tail  <= r_tail + PTR_W'(w_npush);
            r_count <= r_count + CNT_W'(w_npush) - CNT_W'(w_npop);
        end
    end

endmodule
